shift_sequencer: RTL

- Multi-cycle controller for a variable-amount 32-bit shifter in the CPU datapath. It handles sll, srl and sra with a shift amount of 0..31.
- It reuses a narrow fixed-step shift stage each cycle, under a small FSM, instead of a full barrel shifter.
- It uses a start/busy/done handshake so the ALU/control path can stall on it.

---
 rtl/shift_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle sll/srl/sra controller: a narrow STEP-bit shift stage is reused
// each cycle under a three-state FSM with a start/busy/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start_i; data_o holds the last result
// S_SHIFT | shifting work register by min(STEP, remaining) per cycle
// S_DONE  | done_o pulse; data_o valid; may accept a back-to-back start
module shift_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,   // 2**SHAMT_W must equal DATA_W
  parameter int STEP    = 2    // 1, 2 or 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         op_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  data_o
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W+1)'(STEP);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  work_q, work_d;
  logic [SHAMT_W:0]   rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [SHAMT_W:0]   step;
  logic [DATA_W-1:0]  shifted;

  always_comb begin
    step = (rem_q < STEP_V) ? rem_q : STEP_V;
    case (op_q)
      2'b01:   shifted = work_q >> step;
      // sra fills vacated MSBs with the sign bit latched at acceptance
      2'b11:   shifted = (work_q >> step) |
                         (~({DATA_W{1'b1}} >> step) & {DATA_W{sign_q}});
      default: shifted = work_q << step;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          work_d = data_i;
          rem_d  = {1'b0, shamt_i};
          op_d   = op_i;
          sign_d = data_i[DATA_W-1];
          if (shamt_i == '0) begin
            state_d = S_DONE;
            data_d  = data_i;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - step;
        if (rem_d == '0) begin
          state_d = S_DONE;
          data_d  = shifted;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
    end
  end

  assign busy_o = (state_q == S_SHIFT);
  assign done_o = (state_q == S_DONE);
  assign data_o = data_q;

endmodule
